// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single DBus between the load path and the committed-store drain,
// tracking outstanding transaction owners in order so responses return to their issuer.
module dcache_port_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int EX_W         = 8   // packed exception_t width; bit 0 is the ex flag
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ld_req,
  input  logic [2:0]      ld_size,
  input  logic [31:0]     ld_addr,
  output logic            ld_addr_ok,
  output logic            ld_data_ok,
  output logic [31:0]     ld_rdata,
  output logic [EX_W-1:0] ld_ex,
  input  logic            st_req,
  input  logic [3:0]      st_wstrb,
  input  logic [2:0]      st_size,
  input  logic [31:0]     st_addr,
  input  logic [31:0]     st_wdata,
  output logic            st_addr_ok,
  output logic            st_data_ok,
  output logic [EX_W-1:0] st_ex,
  output logic            dcache_req,
  output logic            dcache_wr,
  output logic [3:0]      dcache_wstrb,
  output logic [2:0]      dcache_size,
  output logic [31:0]     dcache_addr,
  output logic [31:0]     dcache_wdata,
  input  logic            dcache_addr_ok,
  input  logic            dcache_data_ok,
  input  logic [31:0]     dcache_rdata,
  input  logic [EX_W-1:0] data_tlb_ex,
  output logic            busy
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic             is_store_q [OUTSTANDING];
  logic             is_store_d [OUTSTANDING];
  logic             cancel_q   [OUTSTANDING];
  logic             cancel_d   [OUTSTANDING];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic full, empty, ld_ok, st_ok, grant_ld, grant_st, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(OUTSTANDING));
  assign empty = (count_q == '0);
  assign busy  = !empty;

  assign ld_ok    = ld_req && !flush && !full;
  assign st_ok    = st_req && !full;
  // A starved load overrides the normal store-first priority.
  assign grant_ld = ld_ok && (!st_ok || starve_q == STV_W'(STARVE_LIMIT));
  assign grant_st = st_ok && !grant_ld;

  assign push = dcache_addr_ok && (grant_ld || grant_st);
  assign pop  = dcache_data_ok && !empty;

  assign ld_addr_ok = dcache_addr_ok && grant_ld;
  assign st_addr_ok = dcache_addr_ok && grant_st;

  // NOTE: every signal gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    dcache_req   = ld_ok || st_ok;
    dcache_wr    = grant_st;
    dcache_wstrb = '0;
    dcache_size  = '0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    if (grant_st) begin
      dcache_wstrb = st_wstrb;
      dcache_size  = st_size;
      dcache_addr  = st_addr;
      dcache_wdata = st_wdata;
    end else if (grant_ld) begin
      dcache_size  = ld_size;
      dcache_addr  = ld_addr;
    end
  end

  always_comb begin
    ld_data_ok = 1'b0;
    ld_rdata   = '0;
    ld_ex      = '0;
    st_data_ok = 1'b0;
    st_ex      = '0;
    if (pop) begin
      if (is_store_q[head_q]) begin
        st_data_ok = 1'b1;
        st_ex      = data_tlb_ex;
      end else if (!cancel_q[head_q] && !flush) begin
        ld_data_ok = 1'b1;
        ld_rdata   = dcache_rdata;
        ld_ex      = data_tlb_ex;
      end
    end
  end

  always_comb begin
    is_store_d = is_store_q;
    cancel_d   = cancel_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    starve_d   = starve_q;

    // Marking free slots is harmless: a push always rewrites the cancel flag.
    if (flush) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (!is_store_q[i]) cancel_d[i] = 1'b1;
      end
    end
    if (push) begin
      is_store_d[tail_q] = grant_st;
      cancel_d[tail_q]   = 1'b0;
      tail_d             = ptr_inc(tail_q);
    end
    if (pop) head_d = ptr_inc(head_q);

    if (ld_addr_ok || !ld_req || flush) begin
      starve_d = '0;
    end else if (st_addr_ok && starve_q != STV_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // NOTE: the owner flags are reset along with the pointers so a stale cancel bit
  // can never be observed; the array is tiny so this costs nothing meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        is_store_q[i] <= 1'b0;
        cancel_q[i]   <= 1'b0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      is_store_q <= is_store_d;
      cancel_q   <= cancel_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: a grant table, directed corner
// sequences and randomized traffic compared against a queue-based owner model.
module tb_dcache_port_arbiter;

  localparam int OUT = 2;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        ld_req, st_req;
  logic [2:0]  ld_size, st_size;
  logic [31:0] ld_addr, st_addr, st_wdata, dcache_rdata;
  logic [3:0]  st_wstrb;
  logic        dcache_addr_ok, dcache_data_ok;
  logic [7:0]  data_tlb_ex;

  logic        ld_addr_ok, ld_data_ok, st_addr_ok, st_data_ok;
  logic [31:0] ld_rdata, dcache_addr, dcache_wdata;
  logic [7:0]  ld_ex, st_ex;
  logic        dcache_req, dcache_wr, busy;
  logic [3:0]  dcache_wstrb;
  logic [2:0]  dcache_size;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIM), .EX_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ld_req(ld_req), .ld_size(ld_size), .ld_addr(ld_addr),
    .ld_addr_ok(ld_addr_ok), .ld_data_ok(ld_data_ok), .ld_rdata(ld_rdata), .ld_ex(ld_ex),
    .st_req(st_req), .st_wstrb(st_wstrb), .st_size(st_size), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_addr_ok(st_addr_ok), .st_data_ok(st_data_ok), .st_ex(st_ex),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_wstrb(dcache_wstrb),
    .dcache_size(dcache_size), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
    .dcache_rdata(dcache_rdata), .data_tlb_ex(data_tlb_ex), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an owner queue and a starvation counter.
  typedef struct packed { bit st; bit canc; } ent_t;
  ent_t q[$];
  int   starve = 0;
  bit   e_push, e_pop, e_ldaok, e_staok;

  task automatic model_check();
    bit full, l_ok, s_ok, l_win, s_win, e_ldd, e_std;
    bit [31:0] e_addr, e_wdata;
    bit [3:0]  e_wstrb;
    bit [2:0]  e_size;
    full  = (q.size() == OUT);
    l_ok  = ld_req && !flush && !full;
    s_ok  = st_req && !full;
    l_win = l_ok && (!s_ok || starve == LIM);
    s_win = s_ok && !l_win;
    e_addr  = s_win ? st_addr  : (l_win ? ld_addr : 32'h0);
    e_size  = s_win ? st_size  : (l_win ? ld_size : 3'h0);
    e_wdata = s_win ? st_wdata : 32'h0;
    e_wstrb = s_win ? st_wstrb : 4'h0;
    e_ldaok = l_win && dcache_addr_ok;
    e_staok = s_win && dcache_addr_ok;
    e_push  = e_ldaok || e_staok;
    e_pop   = dcache_data_ok && q.size() > 0;
    e_std   = e_pop && q[0].st;
    e_ldd   = e_pop && !q[0].st && !q[0].canc && !flush;
    check("dcache_req",   dcache_req,   l_ok || s_ok);
    check("dcache_wr",    dcache_wr,    s_win);
    check("dcache_addr",  dcache_addr,  e_addr);
    check("dcache_size",  dcache_size,  e_size);
    check("dcache_wdata", dcache_wdata, e_wdata);
    check("dcache_wstrb", dcache_wstrb, e_wstrb);
    check("ld_addr_ok",   ld_addr_ok,   e_ldaok);
    check("st_addr_ok",   st_addr_ok,   e_staok);
    check("ld_data_ok",   ld_data_ok,   e_ldd);
    check("ld_rdata",     ld_rdata,     e_ldd ? dcache_rdata : 32'h0);
    check("ld_ex",        ld_ex,        e_ldd ? data_tlb_ex : 8'h0);
    check("st_data_ok",   st_data_ok,   e_std);
    check("st_ex",        st_ex,        e_std ? data_tlb_ex : 8'h0);
    check("busy",         busy,         q.size() != 0);
  endtask

  task automatic model_update();
    ent_t e;
    if (reset) begin
      q.delete();
      starve = 0;
      return;
    end
    if (flush) foreach (q[i]) if (!q[i].st) q[i].canc = 1'b1;
    if (e_pop) void'(q.pop_front());
    if (e_push) begin
      e.st = e_staok;
      e.canc = 1'b0;
      q.push_back(e);
    end
    if (e_ldaok || !ld_req || flush) starve = 0;
    else if (e_staok && starve < LIM) starve++;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    model_check();
    advance();
  endtask

  task automatic idle_inputs();
    flush = 0; ld_req = 0; st_req = 0;
    dcache_addr_ok = 0; dcache_data_ok = 0;
    dcache_rdata = 0; data_tlb_ex = 0;
  endtask

  typedef struct {
    bit ld, st, fl, aok, dok;
    bit x_req, x_wr, x_laok, x_saok;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [5:0] wr_pat;
    vecs[0] = '{0,0,0,1,1, 0,0,0,0};
    vecs[1] = '{1,0,0,1,0, 1,0,1,0};
    vecs[2] = '{1,0,0,0,0, 1,0,0,0};
    vecs[3] = '{0,1,0,1,0, 1,1,0,1};
    vecs[4] = '{1,1,0,1,0, 1,1,0,1};
    vecs[5] = '{1,1,1,1,0, 1,1,0,1};
    vecs[6] = '{1,0,1,1,0, 0,0,0,0};
    vecs[7] = '{0,1,1,0,1, 1,1,0,0};

    reset = 1;
    idle_inputs();
    ld_size = 3'd2; ld_addr = 32'h0000_1000;
    st_size = 3'd1; st_addr = 32'h0000_2000; st_wdata = 32'hCAFE_0001; st_wstrb = 4'b0011;
    repeat (2) @(posedge clk);
    #1;

    // Grant table applied while reset holds the FIFO empty.
    for (int i = 0; i < 8; i++) begin
      ld_req = vecs[i].ld; st_req = vecs[i].st; flush = vecs[i].fl;
      dcache_addr_ok = vecs[i].aok; dcache_data_ok = vecs[i].dok;
      settle();
      check("tbl_req",  dcache_req, vecs[i].x_req);
      check("tbl_wr",   dcache_wr,  vecs[i].x_wr);
      check("tbl_laok", ld_addr_ok, vecs[i].x_laok);
      check("tbl_saok", st_addr_ok, vecs[i].x_saok);
      check("tbl_addr", dcache_addr, !vecs[i].x_req ? 32'h0 : (vecs[i].x_wr ? st_addr : ld_addr));
      check("tbl_dok",  {ld_data_ok, st_data_ok, busy}, 3'b000);
      @(posedge clk); #1;
    end
    idle_inputs();
    reset = 0;
    q.delete(); starve = 0;

    // Idle after reset: everything low.
    settle();
    model_check();
    check("reset_outs", {dcache_req, dcache_wr, ld_addr_ok, st_addr_ok, ld_data_ok, st_data_ok, busy}, 7'h0);
    advance();

    // Single load, data returns three cycles later.
    ld_req = 1; dcache_addr_ok = 1;
    settle(); model_check(); check("sl_addr_ok", ld_addr_ok, 1'b1); advance();
    ld_req = 0; dcache_addr_ok = 0;
    for (int c = 1; c <= 2; c++) begin
      settle(); model_check(); check("sl_busy", busy, 1'b1); advance();
    end
    dcache_data_ok = 1; dcache_rdata = 32'hDEAD_BEEF;
    settle(); model_check();
    check("sl_data_ok", ld_data_ok, 1'b1);
    check("sl_rdata", ld_rdata, 32'hDEAD_BEEF);
    check("sl_busy3", busy, 1'b1);
    advance();
    idle_inputs();
    settle(); model_check(); check("sl_idle", busy, 1'b0); advance();

    // Contention: four store grants, one forced load, stores resume.
    ld_req = 1; st_req = 1; dcache_addr_ok = 1; dcache_data_ok = 1;
    wr_pat = 6'b101111;
    for (int c = 0; c < 6; c++) begin
      settle(); model_check();
      check("starve_wr", dcache_wr, wr_pat[c]);
      advance();
    end
    idle_inputs(); dcache_data_ok = 1;
    cycle();
    idle_inputs();

    // Ordering: store then load fill the FIFO; responses route in order.
    st_req = 1; dcache_addr_ok = 1;
    cycle();
    st_req = 0; ld_req = 1;
    settle(); model_check(); check("ord_ld_aok", ld_addr_ok, 1'b1); advance();
    ld_req = 0; st_req = 1; dcache_data_ok = 1; dcache_rdata = 32'h1234_5678;
    settle(); model_check();
    check("ord_full_req", dcache_req, 1'b0);
    check("ord_st_dok", st_data_ok, 1'b1);
    advance();
    dcache_addr_ok = 0;
    settle(); model_check(); check("ord_ld_dok", ld_data_ok, 1'b1); advance();
    idle_inputs();
    cycle();

    // Flush cancels an in-flight load.
    ld_req = 1; dcache_addr_ok = 1;
    cycle();
    flush = 1;
    settle(); model_check();
    check("fl_no_grant", {dcache_req, ld_addr_ok}, 2'b00);
    advance();
    idle_inputs(); dcache_data_ok = 1; dcache_rdata = 32'hBAD0_BAD0;
    settle(); model_check();
    check("fl_ld_dok", ld_data_ok, 1'b0);
    check("fl_busy", busy, 1'b1);
    advance();
    idle_inputs();
    settle(); model_check(); check("fl_busy_drop", busy, 1'b0); advance();

    // Store survives a flush and carries its exception.
    st_req = 1; dcache_addr_ok = 1;
    cycle();
    idle_inputs(); flush = 1;
    cycle();
    idle_inputs(); dcache_data_ok = 1; data_tlb_ex = 8'h01;
    settle(); model_check();
    check("sf_st_dok", st_data_ok, 1'b1);
    check("sf_st_ex", st_ex[0], 1'b1);
    advance();
    idle_inputs();

    // Reset with two entries outstanding, then a stray response.
    st_req = 1; dcache_addr_ok = 1;
    cycle();
    st_req = 0; ld_req = 1;
    cycle();
    idle_inputs(); reset = 1;
    cycle();
    reset = 0; dcache_data_ok = 1;
    settle(); model_check();
    check("rst_stray", {ld_data_ok, st_data_ok, busy}, 3'b000);
    advance();
    idle_inputs();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 99) < 2);
      flush          = ($urandom_range(0, 99) < 10);
      ld_req         = $urandom_range(0, 1);
      st_req         = $urandom_range(0, 1);
      dcache_addr_ok = ($urandom_range(0, 99) < 60);
      dcache_data_ok = ($urandom_range(0, 99) < 45);
      ld_size  = 3'($urandom);  ld_addr  = $urandom;
      st_size  = 3'($urandom);  st_addr  = $urandom;
      st_wdata = $urandom;      st_wstrb = 4'($urandom);
      dcache_rdata = $urandom;  data_tlb_ex = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
